// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame parser.
//   SYNC_BYTE      : frame start marker
//   parser_state_e : parser FSM states
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DRAIN   = 3'd4
  } parser_state_e;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-stream bundle around the frame parser.
//   in_*      : byte stream from the UART receiver (valid/ready)
//   out_*     : verified payload stream (valid/ready, last marker)
//   frame_ok  : one-cycle pulse per checksum-verified frame
//   frame_err : one-cycle pulse per dropped frame
//   err_count : saturating dropped-frame count
// master = environment side, slave = parser side.
interface uart_frame_parser_if;

  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        frame_ok;
  logic        frame_err;
  logic [15:0] err_count;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, frame_ok, frame_err, err_count
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, frame_ok, frame_err, err_count
  );

endinterface

// File: rtl/frame_buffer.sv
// Payload store: DEPTH x 8 simple dual-port memory.
//   clk       : write clock
//   wr_en     : write strobe
//   wr_addr   : write index
//   wr_data   : write byte
//   rd_addr   : read index (asynchronous read)
//   rd_data_c : byte at rd_addr (combinational)
module frame_buffer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 7
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data_c
);

  logic [7:0] mem [DEPTH];

  // Contents are intentionally not reset; a frame is always fully written before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser: SYNC, LEN, LEN payload bytes, CHK (XOR of LEN and payload).
// Buffers each frame and releases only checksum-verified payloads downstream.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : parser side of uart_frame_parser_if (in/out streams, status pulses, error count)
import uart_pkg::*;

module uart_frame_parser #(
  parameter int unsigned MAX_LEN        = 64,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned LEN_W          = $clog2(MAX_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  uart_frame_parser_if.slave  bus
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam int unsigned TO_W    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST = TO_EN ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TO_LAST);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  parser_state_e state, state_n;

  logic [LEN_W-1:0] len, len_n;
  logic [LEN_W-1:0] wr_idx, wr_idx_n;
  logic [LEN_W-1:0] rd_idx, rd_idx_n;
  logic [7:0]       chk, chk_n;
  logic [TO_W-1:0]  idle_cnt, idle_n;

  logic        in_ready_q, in_ready_n;
  logic        out_valid_q, out_valid_n;
  logic [7:0]  out_data_q, out_data_n;
  logic        out_last_q, out_last_n;
  logic        frame_ok_q, frame_ok_n;
  logic        frame_err_q, frame_err_n;
  logic [15:0] err_count_q, err_count_n;

  logic             in_acc;
  logic             out_acc;
  logic             timeout_hit;
  logic             wr_en;
  logic [LEN_W-1:0] rd_addr;
  logic [7:0]       rd_data;

  assign in_acc  = bus.in_valid && in_ready_q;
  assign out_acc = out_valid_q && bus.out_ready;

  // Expiry is the cycle that would take the idle count to TIMEOUT_CYCLES; an accepted byte wins.
  assign timeout_hit = TO_EN && (idle_cnt == TO_LIMIT) && !in_acc;

  frame_buffer #(
    .DEPTH (MAX_LEN),
    .AW    (LEN_W)
  ) u_buf (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_addr   (wr_idx),
    .wr_data   (bus.in_data),
    .rd_addr   (rd_addr),
    .rd_data_c (rd_data)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      len         <= '0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      chk         <= '0;
      idle_cnt    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state       <= state_n;
      len         <= len_n;
      wr_idx      <= wr_idx_n;
      rd_idx      <= rd_idx_n;
      chk         <= chk_n;
      idle_cnt    <= idle_n;
      in_ready_q  <= in_ready_n;
      out_valid_q <= out_valid_n;
      out_data_q  <= out_data_n;
      out_last_q  <= out_last_n;
      frame_ok_q  <= frame_ok_n;
      frame_err_q <= frame_err_n;
      err_count_q <= err_count_n;
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_n     = state;
    len_n       = len;
    wr_idx_n    = wr_idx;
    rd_idx_n    = rd_idx;
    chk_n       = chk;
    idle_n      = idle_cnt;
    frame_ok_n  = 1'b0;
    frame_err_n = 1'b0;
    wr_en       = 1'b0;
    rd_addr     = rd_idx;
    out_data_n  = out_data_q;
    out_last_n  = out_last_q;

    case (state)
      HUNT: begin
        if (in_acc && (bus.in_data == SYNC_BYTE)) begin
          state_n = LEN;
          idle_n  = '0;
        end
      end

      LEN: begin
        if (in_acc) begin
          idle_n = '0;
          if ((bus.in_data == 8'h00) || (bus.in_data > MAX_LEN_B)) begin
            state_n     = HUNT;
            frame_err_n = 1'b1;
          end else begin
            len_n    = LEN_W'(bus.in_data);
            chk_n    = bus.in_data;
            wr_idx_n = '0;
            state_n  = PAYLOAD;
          end
        end else if (timeout_hit) begin
          state_n     = HUNT;
          frame_err_n = 1'b1;
        end else if (TO_EN) begin
          idle_n = idle_cnt + TO_W'(1);
        end
      end

      PAYLOAD: begin
        if (in_acc) begin
          idle_n   = '0;
          wr_en    = 1'b1;
          chk_n    = chk ^ bus.in_data;
          wr_idx_n = wr_idx + LEN_W'(1);
          if ((wr_idx + LEN_W'(1)) == len) begin
            state_n = CHK;
          end
        end else if (timeout_hit) begin
          state_n     = HUNT;
          frame_err_n = 1'b1;
        end else if (TO_EN) begin
          idle_n = idle_cnt + TO_W'(1);
        end
      end

      CHK: begin
        if (in_acc) begin
          idle_n = '0;
          if (bus.in_data == chk) begin
            frame_ok_n = 1'b1;
            rd_idx_n   = '0;
            rd_addr    = '0;
            out_data_n = rd_data;
            out_last_n = (len == LEN_W'(1));
            state_n    = DRAIN;
          end else begin
            frame_err_n = 1'b1;
            state_n     = HUNT;
          end
        end else if (timeout_hit) begin
          state_n     = HUNT;
          frame_err_n = 1'b1;
        end else if (TO_EN) begin
          idle_n = idle_cnt + TO_W'(1);
        end
      end

      DRAIN: begin
        // Output regs are preloaded from the next index so the presented byte stays stable under stall.
        if (out_acc) begin
          if (out_last_q) begin
            state_n = HUNT;
          end else begin
            rd_idx_n   = rd_idx + LEN_W'(1);
            rd_addr    = rd_idx + LEN_W'(1);
            out_data_n = rd_data;
            out_last_n = ((rd_idx + LEN_W'(1)) == (len - LEN_W'(1)));
          end
        end
      end

      default: begin
        state_n = HUNT;
      end
    endcase

    if (state_n != DRAIN) begin
      out_last_n = 1'b0;
    end

    in_ready_n  = (state_n != DRAIN);
    out_valid_n = (state_n == DRAIN);

    err_count_n = err_count_q;
    if (frame_err_n && (err_count_q != 16'hFFFF)) begin
      err_count_n = err_count_q + 16'd1;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_count = err_count_q;

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Sits directly downstream of the UART receiver and consumes its byte stream through a valid/ready handshake. Frame format: SYNC (0xA5), LEN (1..MAX_LEN), LEN payload bytes, CHK, where CHK is the XOR of LEN and all payload bytes. Each frame is buffered internally. Only checksum-verified payloads are released downstream as a valid/ready byte stream with a last marker. Bad, oversize and stalled frames are dropped and counted.

Parameters:
MAX_LEN, 64, maximum payload bytes per frame; legal range 1..255; sets buffer depth.
TIMEOUT_CYCLES, 100000, idle clk cycles allowed between bytes inside a frame; 0 disables the timeout.
LEN_W, $clog2(MAX_LEN+1), derived width of length and index registers; not to be overridden.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  asynchronous, active-high reset.
in_data  in  8  byte from the UART receiver.
in_valid  in  1  in_data holds an unconsumed byte.
in_ready  out  1  parser accepts a byte this cycle; drives the receiver's data_ready.
out_data  out  8  payload byte.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accepts out_data.
out_last  out  1  high with the final payload byte of a frame.
frame_ok  out  1  one-cycle pulse when a frame passes the checksum.
frame_err  out  1  one-cycle pulse when a frame is dropped.
err_count  out  16  dropped-frame count; saturates at 0xFFFF.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset state: HUNT. out_valid=0, out_last=0, frame_ok=0, frame_err=0, err_count=0. Length, index, checksum and timeout counters are cleared. Buffer contents are not reset. Reset mid-frame or mid-drain discards everything.
- Transfer rule: an input byte transfers when in_valid && in_ready. An output byte transfers when out_valid && out_ready.
- in_ready is 1 in HUNT, LEN, PAYLOAD and CHK, and 0 in DRAIN. During DRAIN, upstream overflow handling is the receiver's concern.
- HUNT: on accepting 0xA5, go to LEN. Any other byte is discarded silently and does not count as an error.
- LEN: on accepting byte L:
  - If L==0 or L>MAX_LEN: go to HUNT, pulse frame_err, increment err_count.
  - Otherwise: len<=L, chk<=L, wr_idx<=0, go to PAYLOAD.
- PAYLOAD: each accepted byte does buf[wr_idx]<=byte, chk<=chk^byte, wr_idx++. After byte number len is accepted, go to CHK. A 0xA5 inside the payload is plain data; there is no resync.
- CHK: on accepting byte C:
  - If C==chk: pulse frame_ok, rd_idx<=0, go to DRAIN.
  - Otherwise: pulse frame_err, increment err_count, go to HUNT.
- DRAIN: out_valid=1, out_data=buf[rd_idx], out_last=(rd_idx==len-1). On transfer, rd_idx++.
  - When the transfer carries out_last, go to HUNT; out_valid is 0 on the next cycle.
  - out_data and out_last are stable while out_valid && !out_ready.
- Timeout (TIMEOUT_CYCLES>0): an idle counter runs only in LEN, PAYLOAD and CHK. It clears on entering LEN and on every accepted byte.
  - When it reaches TIMEOUT_CYCLES: go to HUNT, pulse frame_err, increment err_count.
  - If a byte is accepted in the same cycle the counter would expire, the byte wins and the counter clears.
  - The counter does not run in HUNT or DRAIN. Downstream stall never times out.
- Pulses: frame_ok and frame_err are registered and high for exactly one cycle; they are never both high.
- Latency: frame_ok rises the cycle after CHK is accepted. out_valid rises in that same cycle. First payload byte is available one cycle after the CHK handshake.
- Widths: chk is 8 bits. wr_idx, rd_idx and len are LEN_W bits. The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits. Increments never wrap (bounded by len / saturation).

Decomposition:
- Shared package uart_pkg holds SYNC_BYTE=8'hA5 and the parser state enum (HUNT, LEN, PAYLOAD, CHK, DRAIN).
- Sub-module frame_buffer: MAX_LEN x 8 simple dual-port memory, with synchronous write and asynchronous read at rd_idx. The parser FSM, checksum, counters and timeout stay in uart_frame_parser.

Test Plan:
- Good frame: A5 03 11 22 33 03 with out_ready=1 -> frame_ok pulse, out bytes 11,22,33 with out_last only on 33, err_count=0.
- Bad checksum: A5 02 10 20 31 (expected 0x32) -> frame_err pulse, no out_valid, err_count=1, then A5 01 55 54 -> out 55 with out_last.
- Illegal length: A5 00, then, with MAX_LEN=4, A5 05 -> two frame_err pulses, err_count=2, parser back in HUNT accepting garbage 0x00/0xFF silently.
- Backpressure: good frame of 4 bytes, out_ready held 0 for 20 cycles then toggled every other cycle -> in_ready=0 throughout DRAIN, out_data stable while stalled, exact bytes/order, in_ready=1 after last transfer.
- Timeout: TIMEOUT_CYCLES=50, send A5 02 11, then idle 50 cycles -> frame_err exactly at expiry, err_count=1; a byte arriving on cycle 50 instead -> accepted, no error.
- Async reset mid-PAYLOAD and mid-DRAIN -> outputs drop immediately to reset values, next A5 01 7E 7F frame delivers 7E correctly.
